// File: rtl/binary_to_bcd.sv
// binary_to_bcd
// Sequential double-dabble converter: unsigned binary count in, three BCD
// digits (hundreds/tens/ones) out, with a start/busy/done handshake.
// Values above 999 produce all-4'hF digits and raise overflow so the
// downstream 7-segment decoder shows dashes.
// WIDTH legal range is 4..16; the bit counter is sized for 16.

module binary_to_bcd #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  // Combined {BCD[11:0], binary[WIDTH-1:0]} working register width.
  localparam int SR_W = WIDTH + 12;

  // FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Largest value representable in three BCD digits.
  localparam logic [16:0] MAX_BCD = 17'd999;

  // Add-3 correction of one BCD nibble: digits 5..9 would exceed 9 after the
  // following doubling, so bias them by 3 to force the decimal carry.
  function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Correct all three BCD nibbles; the binary part is never touched.
  function automatic logic [11:0] add3_bcd(input logic [11:0] bcd);
    return {add3_nibble(bcd[11:8]), add3_nibble(bcd[7:4]), add3_nibble(bcd[3:0])};
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [SR_W-1:0] r_shift;
  logic [4:0]      r_cnt;
  logic            r_ovf_pend;
  logic            r_busy;
  logic            r_done;
  logic            r_overflow;
  logic [3:0]      r_hundreds;
  logic [3:0]      r_tens;
  logic [3:0]      r_ones;

  // Next-state values
  logic [1:0]      w_state_nxt;
  logic [SR_W-1:0] w_shift_nxt;
  logic [4:0]      w_cnt_nxt;
  logic            w_ovf_pend_nxt;
  logic            w_overflow_nxt;
  logic [3:0]      w_hundreds_nxt;
  logic [3:0]      w_tens_nxt;
  logic [3:0]      w_ones_nxt;

  // One double-dabble iteration and the input range test
  logic [SR_W-1:0] w_corrected;
  logic [SR_W-1:0] w_shift_step;
  logic            w_in_ovf;

  // One iteration: correct the BCD nibbles, then shift everything left by one.
  always_comb begin
    w_corrected  = {add3_bcd(r_shift[SR_W-1:WIDTH]), r_shift[WIDTH-1:0]};
    w_shift_step = {w_corrected[SR_W-2:0], 1'b0};
    w_in_ovf     = (17'(bin_in) > MAX_BCD);
  end

  // FSM next-state, working register and result register update logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_ovf_pend_nxt = r_ovf_pend;
    w_overflow_nxt = r_overflow;
    w_hundreds_nxt = r_hundreds;
    w_tens_nxt     = r_tens;
    w_ones_nxt     = r_ones;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_shift_nxt    = {12'b0, bin_in};
          w_cnt_nxt      = 5'(WIDTH);
          w_ovf_pend_nxt = w_in_ovf;
          w_state_nxt    = ST_SHIFT;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        w_shift_nxt = w_shift_step;
        w_cnt_nxt   = r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          // Last iteration: publish the result taken from the shifted value.
          w_state_nxt = ST_DONE;
          if (r_ovf_pend) begin
            w_overflow_nxt = 1'b1;
            w_hundreds_nxt = 4'hF;
            w_tens_nxt     = 4'hF;
            w_ones_nxt     = 4'hF;
          end else begin
            w_overflow_nxt = 1'b0;
            w_hundreds_nxt = w_shift_step[WIDTH+11:WIDTH+8];
            w_tens_nxt     = w_shift_step[WIDTH+7:WIDTH+4];
            w_ones_nxt     = w_shift_step[WIDTH+3:WIDTH];
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_DONE: begin
        // start is ignored here; a new request is only sampled in IDLE.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequential state: asynchronous reset aborts any conversion silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_cnt      <= 5'd0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_hundreds <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf_pend <= w_ovf_pend_nxt;
      // busy/done are registered copies of the next-state decode so they line
      // up with r_state without any combinational output path.
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
      r_overflow <= w_overflow_nxt;
      r_hundreds <= w_hundreds_nxt;
      r_tens     <= w_tens_nxt;
      r_ones     <= w_ones_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign hundreds = r_hundreds;
  assign tens     = r_tens;
  assign ones     = r_ones;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed self-checking bench for binary_to_bcd (WIDTH = 10).
module tb_binary_to_bcd;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] bin_in;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  int vectors     = 0;
  int miscompares = 0;

  // Last published result, used to check outputs hold mid-conversion.
  logic [3:0] cur_h = 4'd0;
  logic [3:0] cur_t = 4'd0;
  logic [3:0] cur_o = 4'd0;
  logic       cur_v = 1'b0;

  binary_to_bcd #(.WIDTH(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Run one conversion; glitch pulses start during SHIFT and DONE.
  task automatic convert(input logic [9:0] v, input logic [3:0] eh, input logic [3:0] et,
                         input logic [3:0] eo, input logic eovf, input bit glitch);
    int k;
    int busy_cnt;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);           // just after E0
    start  = 1'b0;
    bin_in = 10'd777;         // must not affect the captured value
    k = 0;
    busy_cnt = 0;
    chk("busy_after_accept", 16'(busy), 16'd1);
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) busy_cnt++;
      chk("hold_outputs", {hundreds, tens, ones, 3'b000, overflow},
          {cur_h, cur_t, cur_o, 3'b000, cur_v});
      if (glitch && k == 3) begin
        start  = 1'b1;
        bin_in = 10'd456;
      end else if (glitch && k == 4) begin
        start  = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk("latency", 16'(k), 16'd10);
    if (busy === 1'b1) busy_cnt++;
    chk("done_implies_busy", 16'(busy), 16'd1);
    chk("hundreds", 16'(hundreds), 16'(eh));
    chk("tens", 16'(tens), 16'(et));
    chk("ones", 16'(ones), 16'(eo));
    chk("overflow", 16'(overflow), 16'(eovf));
    if (glitch) begin
      start  = 1'b1;          // sampled while in DONE
      bin_in = 10'd456;
    end
    @(negedge clk);
    chk("done_one_cycle", 16'(done), 16'd0);
    chk("busy_drop", 16'(busy), 16'd0);
    chk("busy_cycles", 16'(busy_cnt), 16'd11);
    if (glitch) begin
      start = 1'b0;
      @(negedge clk);
      chk("ignored_start_busy", 16'(busy), 16'd0);
      chk("ignored_start_done", 16'(done), 16'd0);
      chk("ignored_start_digits", {hundreds, tens, ones, 3'b000, overflow},
          {eh, et, eo, 3'b000, eovf});
    end
    cur_h = eh;
    cur_t = et;
    cur_o = eo;
    cur_v = eovf;
  endtask

  initial begin
    int last;
    int pulses;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = 10'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", {hundreds, tens, ones, 1'b0, busy, done, overflow}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {hundreds, tens, ones, 1'b0, busy, done, overflow}, 16'h0000);

    // Basic conversions
    convert(10'd0,    4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    convert(10'd999,  4'd9, 4'd9, 4'd9, 1'b0, 1'b0);
    convert(10'd507,  4'd5, 4'd0, 4'd7, 1'b0, 1'b0);
    convert(10'd60,   4'd0, 4'd6, 4'd0, 1'b0, 1'b0);

    // Out of range
    convert(10'd1000, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
    convert(10'd1023, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
    convert(10'd12,   4'd0, 4'd1, 4'd2, 1'b0, 1'b0);

    // start during SHIFT and DONE is ignored
    convert(10'd123,  4'd1, 4'd2, 4'd3, 1'b0, 1'b1);

    // start held high: one conversion every 12 cycles
    @(negedge clk);
    start  = 1'b1;
    bin_in = 10'd45;
    last   = -1;
    pulses = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);         // just after E_k
      if (done === 1'b1) begin
        pulses++;
        chk("stream_digits", {hundreds, tens, ones, 3'b000, overflow}, 16'h0450);
        if (last < 0) begin
          chk("stream_first_done", 16'(k), 16'd10);
        end else begin
          chk("stream_period", 16'(k - last), 16'd12);
        end
        last = k;
      end
    end
    start = 1'b0;
    chk("stream_pulses", 16'(pulses), 16'd3);
    @(negedge clk);
    chk("stream_idle", 16'(busy), 16'd0);
    cur_h = 4'd0;
    cur_t = 4'd4;
    cur_o = 4'd5;
    cur_v = 1'b0;

    // Reset in the middle of a conversion
    convert(10'd888, 4'd8, 4'd8, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 10'd321;
    @(negedge clk);           // just after E0
    start  = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_abort", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {hundreds, tens, ones, 1'b0, busy, done, overflow}, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 16'(done), 16'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_stays_idle", {busy, done}, 16'd0);
    end
    cur_h = 4'd0;
    cur_t = 4'd0;
    cur_o = 4'd0;
    cur_v = 1'b0;
    convert(10'd321, 4'd3, 4'd2, 4'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd.md
# binary_to_bcd

Sequential double-dabble converter that turns an unsigned binary count (e.g. bottles returned, credit earned) into three BCD digits: hundreds, tens and ones. It sits upstream of the BCD-to-7-segment display decoder and feeds its hundreds/tens/ones inputs directly. It uses a start/busy/done handshake with the counting logic. Out-of-range values produce all-4'hF digits, which the decoder renders as dashes.

## Interface
- WIDTH, 10, bit width of the binary input; legal range 4..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  WIDTH  unsigned value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- overflow  output  1  captured value was > 999; updated together with the digits.
- hundreds  output  4  BCD hundreds digit, or 4'hF on overflow.
- tens  output  4  BCD tens digit, or 4'hF on overflow.
- ones  output  4  BCD ones digit, or 4'hF on overflow.

## Operation
- One clock; reset is asynchronous and active-low.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Wait for start.
  - On a clk edge with start=1: load the shift register with {12'b0, bin_in}, set bit counter = WIDTH, set the overflow-pending flag = (bin_in > 999), go to SHIFT.
- SHIFT:
  - Each edge: for each 4-bit BCD nibble, add 3 if the nibble ≥ 5, then shift the whole {BCD, binary} register left by 1, then decrement the counter.
  - On the edge where the counter goes 1→0, load the output registers from the final BCD nibbles and go to DONE.
  - The output registers are loaded with all 4'hF instead when overflow is pending.
- DONE: done=1 for exactly this one cycle; next edge returns to IDLE.
- Shift register width is WIDTH+12; the add-3 correction applies to BCD nibbles only, never to the binary part.
- hundreds/tens/ones/overflow hold their last result until the next DONE entry. No change is visible mid-conversion.
- start while busy=1 (SHIFT or DONE) is ignored; no queuing.
- bin_in changes after acceptance have no effect.
- Reset (any time, including mid-conversion): state→IDLE immediately. The conversion is aborted with no done pulse.

## Timing
- Reset values: busy=0, done=0, overflow=0, hundreds=0, tens=0, ones=0, state=IDLE.
- Let E0 be the edge that accepts start.
  - busy=1 after E0.
  - Shifts occur at E1..E_WIDTH.
  - Outputs are updated and done=1 after E_WIDTH.
  - done=0 and busy=0 after E_{WIDTH+1}.
- Latency: start edge to done visible = WIDTH edges (10 for the default).
- Earliest next accept is E_{WIDTH+2}.
- Throughput: one conversion per WIDTH+2 cycles when start is held high continuously.
- done and busy are never both low during a conversion; done=1 implies busy=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then start with bin_in=0 → done after 10 edges; digits 0,0,0; overflow=0; busy high for exactly 11 cycles.
- bin_in=999 → 9,9,9 with overflow=0. Then bin_in=507 → 5,0,7. Then bin_in=60 → 0,6,0. Digits stay stable between done pulses.
- bin_in=1000 and bin_in=1023 → hundreds=tens=ones=4'hF and overflow=1. A following bin_in=12 → 0,1,2 with overflow=0.
- Start 123 accepted, then start pulsed with bin_in=456 during SHIFT and during DONE → both ignored; result 1,2,3; exactly one done pulse.
- start held high continuously with bin_in=45 → done pulses every 12 cycles; digits 0,4,5 each time.
- Convert 888, then assert rst_n=0 at E5 of a 321 conversion → all outputs 0 immediately, no done pulse. After release, a new start with 321 → 3,2,1.
